// File: rtl/rvga_scoreboard.sv
// rvga_scoreboard: per-register in-flight write counters gating issue on RAW and WAW-overflow hazards
module rvga_scoreboard #(
   parameter int cnt_width_p       = 2,
   parameter int stall_cnt_width_p = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         issue_v_i,
   input  logic                         issue_rs1_v_i,
   input  logic                         issue_rs2_v_i,
   input  logic [4:0]                   issue_rs1_i,
   input  logic [4:0]                   issue_rs2_i,
   input  logic [4:0]                   issue_rd_i,
   input  logic                         issue_rd_w_v_i,
   output logic                         issue_ready_o,
   input  logic                         wb_v_i,
   input  logic [4:0]                   wb_rd_i,
   input  logic                         flush_i,
   output logic [31:0]                  pending_o,
   output logic [stall_cnt_width_p-1:0] stall_cnt_o,
   output logic                         err_o
);
   localparam logic [cnt_width_p-1:0]       cnt_one_c   = 1;
   localparam logic [stall_cnt_width_p-1:0] stall_one_c = 1;
   logic [31:0][cnt_width_p-1:0]  count_q, count_d;
   logic [stall_cnt_width_p-1:0]  stall_q, stall_d;
   logic                          err_q, err_d;
   logic                          raw_hz, waw_hz, accept, inc, dec;
   // Hazard detection looks only at registered counts, so a same-cycle writeback never bypasses
   always_comb begin
      raw_hz = (issue_rs1_v_i & (issue_rs1_i != 5'd0) & (count_q[issue_rs1_i] != '0))
             | (issue_rs2_v_i & (issue_rs2_i != 5'd0) & (count_q[issue_rs2_i] != '0));
      waw_hz = issue_rd_w_v_i & (issue_rd_i != 5'd0) & (count_q[issue_rd_i] == '1);
      issue_ready_o = issue_v_i & ~flush_i & ~raw_hz & ~waw_hz;
      accept = issue_v_i & issue_ready_o;
   end
   // Next counts: flush wins; simultaneous inc and dec of one register cancel out
   always_comb begin
      count_d = count_q;
      count_d[0] = '0;
      inc = 1'b0;
      dec = 1'b0;
      for (int r = 1; r < 32; r++) begin
         inc = accept & issue_rd_w_v_i & (issue_rd_i == 5'(r));
         dec = wb_v_i & (wb_rd_i == 5'(r)) & (count_q[r] != '0);
         count_d[r] = flush_i ? '0
                    : (inc & ~dec) ? count_q[r] + cnt_one_c
                    : (dec & ~inc) ? count_q[r] - cnt_one_c
                    : count_q[r];
      end
   end
   // Sticky error on writeback to an idle register, and saturating stall counter
   always_comb begin
      err_d = err_q | (~flush_i & wb_v_i & (wb_rd_i != 5'd0) & (count_q[wb_rd_i] == '0));
      stall_d = (issue_v_i & ~issue_ready_o & (stall_q != '1)) ? stall_q + stall_one_c : stall_q;
   end
   // Pending bit per register mirrors a nonzero count; x0 is never pending
   always_comb begin
      pending_o = '0;
      for (int r = 1; r < 32; r++) pending_o[r] = count_q[r] != '0;
   end
   // State registers with asynchronous reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
         stall_q <= '0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         stall_q <= stall_d;
         err_q   <= err_d;
      end
   end
   assign stall_cnt_o = stall_q;
   assign err_o       = err_q;
endmodule

// File: doc/rvga_scoreboard.md
RVGA_SCOREBOARD -- requirements
Module: rvga_scoreboard

Parameters
REQ-001 SHALL provide cnt_width_p, default 2: width of the per-register in-flight write counter; maximum in flight per register = 2^cnt_width_p - 1.
REQ-002 SHALL provide stall_cnt_width_p, default 16: width of the saturating stall-cycle counter.

Interface
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 issue_v_i  in  1  decode presents an instruction this cycle.
REQ-006 issue_rs1_v_i, issue_rs2_v_i  in  1 each  instruction reads rs1 or rs2 respectively.
REQ-007 issue_rs1_i, issue_rs2_i, issue_rd_i  in  5 each  register indices.
REQ-008 issue_rd_w_v_i  in  1  instruction writes rd.
REQ-009 issue_ready_o  out  1  instruction accepted this cycle; decode/rfetch advance only when issue_v_i & issue_ready_o.
REQ-010 wb_v_i  in  1  writeback writes wb_rd_i this cycle (same strobe as the regfile write enable).
REQ-011 wb_rd_i  in  5  writeback register index.
REQ-012 flush_i  in  1  pipeline flush; discards all pending writes.
REQ-013 pending_o  out  32  bit r = 1 iff count[r] != 0.
REQ-014 stall_cnt_o  out  stall_cnt_width_p  saturating count of stalled cycles.
REQ-015 err_o  out  1  sticky error flag: writeback to a register with no pending write.

Function
REQ-016 SHALL hold count[1..31], each cnt_width_p bits wide; count[0] SHALL be constant 0, and pending_o[0] SHALL be constant 0.
REQ-017 RAW hazard: issue_rsN_v_i & (issue_rsN_i != 0) & (count[issue_rsN_i] != 0), for N = 1 or 2.
REQ-018 RAW evaluation SHALL use registered counts only; a same-cycle wb_v_i to that register SHALL NOT clear the hazard (no bypass).
REQ-019 WAW-overflow hazard: issue_rd_w_v_i & (issue_rd_i != 0) & (count[issue_rd_i] == max); a same-cycle wb to that register SHALL NOT clear it.
REQ-020 issue_ready_o SHALL equal issue_v_i & ~flush_i & ~RAW hazard & ~WAW-overflow hazard, combinationally.
REQ-021 On accept (issue_v_i & issue_ready_o) with issue_rd_w_v_i and issue_rd_i != 0: count[issue_rd_i] SHALL increment by 1.
REQ-022 On wb_v_i with wb_rd_i != 0 and count[wb_rd_i] != 0: count[wb_rd_i] SHALL decrement by 1.
REQ-023 Same-cycle increment and decrement of the same register SHALL leave its count unchanged.
REQ-024 wb_v_i to a register with count 0 (wb_rd_i != 0): count SHALL remain 0 and err_o SHALL set; err_o SHALL clear only on reset.
REQ-025 wb_v_i with wb_rd_i == 0 and issue to rd 0 SHALL have no effect on any count.
REQ-026 flush_i SHALL zero all counts at the next edge and SHALL take priority over a same-cycle issue or wb; err checking SHALL be suppressed that cycle.
REQ-027 stall_cnt_o SHALL increment each cycle in which issue_v_i & ~issue_ready_o, and SHALL saturate at all-ones.
REQ-028 Counts SHALL never wrap: no increment at max (guaranteed by REQ-019), no decrement at 0.
REQ-029 Latency: count updates SHALL be visible on pending_o and in hazard checks one cycle after the causing edge.

Reset
REQ-030 While rst_i is high, asynchronously: all counts = 0, pending_o = 0, stall_cnt_o = 0, err_o = 0; issue_ready_o then follows REQ-020 with zero counts.
REQ-031 Reset asserted mid-operation SHALL discard all pending writes; no state survives.

Verification
REQ-032 Issue rd=5 writing, next cycle issue rs1=5 -> issue_ready_o=0, pending_o[5]=1, stall_cnt_o increments; wb_v_i rd=5 -> ready=1 the cycle after the wb edge, not during the wb cycle.
REQ-033 Issue rd=0 writing, then read rs1=0 -> pending_o=0, no stall.
REQ-034 Three accepted issues to rd=7 (cnt_width_p=2) -> count 3, fourth issue to rd=7 stalls; simultaneous issue rd=7 and wb rd=7 at count 2 -> count stays 2.
REQ-035 wb_v_i rd=9 with count 0 -> err_o=1, pending_o unchanged; err_o stays 1 until rst_i.
REQ-036 Set pending on regs 3, 4, 31, then assert flush_i together with issue_v_i rd=6 -> issue_ready_o=0, pending_o=0 next cycle, reg 6 not pending.
REQ-037 Hold a RAW stall for 2^16+5 cycles -> stall_cnt_o=0xFFFF; assert rst_i asynchronously mid-stall -> all outputs zero without a clock edge.
